// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared MIPS control definitions: opcode/funct/regimm constants, ALU
// operation codes, the branch-type enum, the control-bundle struct carried
// through ID/EX, and the pipeline controller FSM state type.
// No ports (package).
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

  // Primary opcodes (Instr[31:26])
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_MUL    = 6'b011100;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LH     = 6'b100001;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SH     = 6'b101001;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] FUNCT_JR  = 6'b001000;

  // regimm sub-opcodes (Instr[20:16])
  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;

  // ALU operation codes
  localparam logic [3:0] ALU_MEM   = 4'b0000;
  localparam logic [3:0] ALU_ADDI  = 4'b0001;
  localparam logic [3:0] ALU_RTYPE = 4'b0010;
  localparam logic [3:0] ALU_BGEZ  = 4'b0011;
  localparam logic [3:0] ALU_BEQ   = 4'b0100;
  localparam logic [3:0] ALU_BNE   = 4'b0101;
  localparam logic [3:0] ALU_BGTZ  = 4'b0110;
  localparam logic [3:0] ALU_BLEZ  = 4'b0111;
  localparam logic [3:0] ALU_BLTZ  = 4'b1000;
  localparam logic [3:0] ALU_JUMP  = 4'b1001;
  localparam logic [3:0] ALU_ANDI  = 4'b1010;
  localparam logic [3:0] ALU_ORI   = 4'b1011;
  localparam logic [3:0] ALU_XORI  = 4'b1100;
  localparam logic [3:0] ALU_SLTI  = 4'b1101;
  localparam logic [3:0] ALU_MUL   = 4'b1111;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_JUMP = 2'd1,   // j / jal
    BR_JR   = 2'd2,
    BR_COND = 2'd3
  } branch_type_e;

  // Control bundle registered into the ID/EX slice. An all-zero value is a
  // bubble / NOP.
  typedef struct packed {
    logic         reg_dst;
    logic         mem_read;
    logic         mem_to_reg;
    logic         mem_write;
    logic         alu_src;
    logic         reg_write;
    logic         jal;
    logic [3:0]   alu_op;
    branch_type_e branch_type;
    logic [4:0]   write_reg;
  } ctrl_bundle_t;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MUL_WAIT = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/ctrl_decode.sv
// -----------------------------------------------------------------------------
// ctrl_decode
// Purely combinational decode of one MIPS instruction into the control bundle,
// the resolved destination register, and which source registers it reads.
// Ports:
//   i_instr     in  32  instruction word from IF/ID
//   o_ctrl      out     decoded control bundle (all zero for unknown encodings)
//   o_reads_rs  out  1  instruction consumes rs
//   o_reads_rt  out  1  instruction consumes rt
// -----------------------------------------------------------------------------
module ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [31:0]  i_instr,
  output ctrl_bundle_t o_ctrl,
  output logic         o_reads_rs,
  output logic         o_reads_rt
);

  logic [5:0] w_op;
  logic [4:0] w_rt;
  logic [4:0] w_rd;
  logic [5:0] w_funct;
  logic       w_known;
  logic       w_unused_shamt;

  assign w_op           = i_instr[31:26];
  assign w_rt           = i_instr[20:16];
  assign w_rd           = i_instr[15:11];
  assign w_funct        = i_instr[5:0];
  assign w_unused_shamt = ^i_instr[10:6];

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    o_ctrl     = '0;
    o_reads_rs = 1'b1;
    o_reads_rt = 1'b0;
    w_known    = 1'b1;

    case (w_op)
      OP_RTYPE: begin
        if (w_funct == FUNCT_JR) begin
          o_ctrl.alu_op      = ALU_JUMP;
          o_ctrl.branch_type = BR_JR;
        end else begin
          o_ctrl.alu_op    = ALU_RTYPE;
          o_ctrl.reg_dst   = 1'b1;
          o_ctrl.reg_write = 1'b1;
          o_reads_rt       = 1'b1;
        end
      end
      OP_REGIMM: begin
        o_ctrl.branch_type = BR_COND;
        if (w_rt == RT_BGEZ)      o_ctrl.alu_op = ALU_BGEZ;
        else if (w_rt == RT_BLTZ) o_ctrl.alu_op = ALU_BLTZ;
        else                      w_known = 1'b0;
      end
      OP_J: begin
        o_ctrl.alu_op      = ALU_JUMP;
        o_ctrl.branch_type = BR_JUMP;
        o_reads_rs         = 1'b0;
      end
      OP_JAL: begin
        o_ctrl.alu_op      = ALU_JUMP;
        o_ctrl.branch_type = BR_JUMP;
        o_ctrl.reg_write   = 1'b1;
        o_ctrl.jal         = 1'b1;
        o_reads_rs         = 1'b0;
      end
      OP_BEQ, OP_BNE: begin
        o_ctrl.alu_op      = (w_op == OP_BEQ) ? ALU_BEQ : ALU_BNE;
        o_ctrl.branch_type = BR_COND;
        o_reads_rt         = 1'b1;
      end
      OP_BGTZ, OP_BLEZ: begin
        o_ctrl.alu_op      = (w_op == OP_BGTZ) ? ALU_BGTZ : ALU_BLEZ;
        o_ctrl.branch_type = BR_COND;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: begin
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.reg_write = 1'b1;
        case (w_op)
          OP_ADDI: o_ctrl.alu_op = ALU_ADDI;
          OP_ANDI: o_ctrl.alu_op = ALU_ANDI;
          OP_ORI:  o_ctrl.alu_op = ALU_ORI;
          OP_XORI: o_ctrl.alu_op = ALU_XORI;
          default: o_ctrl.alu_op = ALU_SLTI;
        endcase
      end
      OP_LW, OP_LH, OP_LB: begin
        o_ctrl.alu_op     = ALU_MEM;
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.mem_read   = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
      end
      OP_SW, OP_SH, OP_SB: begin
        o_ctrl.alu_op    = ALU_MEM;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.mem_write = 1'b1;
        o_reads_rt       = 1'b1;
      end
      OP_MUL: begin
        o_ctrl.alu_op    = ALU_MUL;
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_reads_rt       = 1'b1;
      end
      default: w_known = 1'b0;
    endcase

    // Destination: jal links to $31, otherwise rd or rt by RegDst.
    if (o_ctrl.jal)          o_ctrl.write_reg = 5'd31;
    else if (o_ctrl.reg_dst) o_ctrl.write_reg = w_rd;
    else                     o_ctrl.write_reg = w_rt;

    // $0 is hardwired; a write to it is architecturally a no-op.
    if (o_ctrl.write_reg == 5'd0) o_ctrl.reg_write = 1'b0;

    // Unknown encodings become a NOP that reads nothing.
    if (!w_known) begin
      o_ctrl     = '0;
      o_reads_rs = 1'b0;
      o_reads_rt = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_controller.sv
// -----------------------------------------------------------------------------
// pipe_controller
// Decodes the ID-stage instruction into the ID/EX control slice and generates
// load-use stalls, multi-cycle mul stalls and branch/jump flushes.
// Ports:
//   Clk, Rst (async, active-high)
//   Instr[31:0], InstrValid      instruction held in IF/ID
//   BranchTaken                  EX resolved a taken branch/jump this cycle
//   Ex*                          registered EX control (bundle, dest, valid)
//   StallIF                      hold PC and IF/ID this cycle
//   FlushID                      load bubble into IF/ID at next edge
//   MulBusy                      multi-cycle mul occupying EX
// -----------------------------------------------------------------------------
module pipe_controller
  import mips_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 3,
  parameter bit LOAD_USE_EN = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Instr,
  input  logic        InstrValid,
  input  logic        BranchTaken,
  output logic        ExRegDst,
  output logic        ExMemRead,
  output logic        ExMemToReg,
  output logic        ExMemWrite,
  output logic        ExALUSrc,
  output logic        ExRegWrite,
  output logic        ExJal,
  output logic [3:0]  ExALUOp,
  output logic [1:0]  ExBranchType,
  output logic [4:0]  ExWriteReg,
  output logic        ExValid,
  output logic        StallIF,
  output logic        FlushID,
  output logic        MulBusy
);

  localparam int CNT_W = $clog2(MUL_LATENCY + 1);

  ctrl_state_e  r_state;
  ctrl_state_e  w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  ctrl_bundle_t r_ex_ctrl;
  logic         r_ex_valid;

  ctrl_bundle_t w_dec_ctrl;
  logic         w_reads_rs;
  logic         w_reads_rt;
  logic         w_load_use;
  logic         w_ex_bubble;
  logic         w_mul_issue;

  ctrl_decode u_decode (
    .i_instr    (Instr),
    .o_ctrl     (w_dec_ctrl),
    .o_reads_rs (w_reads_rs),
    .o_reads_rt (w_reads_rt)
  );

  // A load in EX whose result the ID instruction needs cannot be forwarded in
  // time; $0 destinations never create a dependency.
  assign w_load_use = LOAD_USE_EN && r_ex_valid && r_ex_ctrl.mem_read &&
                      (r_ex_ctrl.write_reg != 5'd0) && InstrValid &&
                      ((w_reads_rs && (Instr[25:21] == r_ex_ctrl.write_reg)) ||
                       (w_reads_rt && (Instr[20:16] == r_ex_ctrl.write_reg)));

  assign w_ex_bubble = BranchTaken || w_load_use || !InstrValid;
  assign w_mul_issue = !w_ex_bubble && (w_dec_ctrl.alu_op == ALU_MUL);

  // FSM state register
  always_ff @(posedge Clk or posedge Rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (Rst) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // FSM next state: the counter holds the EX cycles still owed after the
  // first one, so MUL_WAIT lasts MUL_LATENCY-1 cycles.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_mul_issue && (MUL_LATENCY > 1)) begin
          w_state_next = ST_MUL_WAIT;
          w_cnt_next   = CNT_W'(MUL_LATENCY - 1);
        end
      end
      ST_MUL_WAIT: begin
        w_cnt_next = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) w_state_next = ST_RUN;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  // FSM outputs: forced low while reset is asserted.
  always_comb begin
    MulBusy = 1'b0;
    StallIF = 1'b0;
    FlushID = 1'b0;
    if (!Rst) begin
      if (r_state == ST_MUL_WAIT) begin
        MulBusy = 1'b1;
        StallIF = 1'b1;
      end else begin
        FlushID = BranchTaken;
        StallIF = w_load_use && !BranchTaken;
      end
    end
  end

  // ID/EX control slice: hold during a mul, else bubble or decoded bundle.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_ex_ctrl  <= '0;
      r_ex_valid <= 1'b0;
    end else if (r_state != ST_MUL_WAIT) begin
      if (w_ex_bubble) begin
        r_ex_ctrl  <= '0;
        r_ex_valid <= 1'b0;
      end else begin
        r_ex_ctrl  <= w_dec_ctrl;
        r_ex_valid <= 1'b1;
      end
    end
  end

  assign ExRegDst     = r_ex_ctrl.reg_dst;
  assign ExMemRead    = r_ex_ctrl.mem_read;
  assign ExMemToReg   = r_ex_ctrl.mem_to_reg;
  assign ExMemWrite   = r_ex_ctrl.mem_write;
  assign ExALUSrc     = r_ex_ctrl.alu_src;
  assign ExRegWrite   = r_ex_ctrl.reg_write;
  assign ExJal        = r_ex_ctrl.jal;
  assign ExALUOp      = r_ex_ctrl.alu_op;
  assign ExBranchType = r_ex_ctrl.branch_type;
  assign ExWriteReg   = r_ex_ctrl.write_reg;
  assign ExValid      = r_ex_valid;

endmodule

// File: tb/tb_pipe_controller.sv
// -----------------------------------------------------------------------------
// tb_pipe_controller
// Directed scenarios plus a randomized instruction stream checked against a
// behavioural model of the ID/EX control slice and its stall/flush rules.
// -----------------------------------------------------------------------------
module tb_pipe_controller;

  localparam int MUL_LAT = 3;

  logic        Clk;
  logic        Rst;
  logic [31:0] Instr;
  logic        InstrValid;
  logic        BranchTaken;
  logic        ExRegDst, ExMemRead, ExMemToReg, ExMemWrite, ExALUSrc, ExRegWrite, ExJal;
  logic [3:0]  ExALUOp;
  logic [1:0]  ExBranchType;
  logic [4:0]  ExWriteReg;
  logic        ExValid, StallIF, FlushID, MulBusy;

  int checks = 0;
  int errors = 0;

  pipe_controller #(.MUL_LATENCY(MUL_LAT), .LOAD_USE_EN(1'b1)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Instr        (Instr),
    .InstrValid   (InstrValid),
    .BranchTaken  (BranchTaken),
    .ExRegDst     (ExRegDst),
    .ExMemRead    (ExMemRead),
    .ExMemToReg   (ExMemToReg),
    .ExMemWrite   (ExMemWrite),
    .ExALUSrc     (ExALUSrc),
    .ExRegWrite   (ExRegWrite),
    .ExJal        (ExJal),
    .ExALUOp      (ExALUOp),
    .ExBranchType (ExBranchType),
    .ExWriteReg   (ExWriteReg),
    .ExValid      (ExValid),
    .StallIF      (StallIF),
    .FlushID      (FlushID),
    .MulBusy      (MulBusy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Expected EX contents plus which registers the instruction reads.
  typedef struct packed {
    logic       reg_dst, mem_read, mem_to_reg, mem_write, alu_src, reg_write, jal;
    logic [3:0] alu;
    logic [1:0] bt;
    logic [4:0] wreg;
    logic       rrs, rrt, is_mul;
  } exp_t;

  // Output vector: [21:15] flags, [14:11] ALUOp, [10:9] BranchType,
  // [8:4] WriteReg, [3] ExValid, [2] StallIF, [1] FlushID, [0] MulBusy.
  function automatic logic [21:0] outs();
    return {ExRegDst, ExMemRead, ExMemToReg, ExMemWrite, ExALUSrc, ExRegWrite, ExJal,
            ExALUOp, ExBranchType, ExWriteReg, ExValid, StallIF, FlushID, MulBusy};
  endfunction

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  // Reference decode straight from the opcode table.
  function automatic exp_t model_decode(input logic [31:0] ins);
    exp_t d;
    logic [5:0] op;
    logic [4:0] rt, rd;
    bit known;
    op = ins[31:26]; rt = ins[20:16]; rd = ins[15:11];
    d = '0; d.rrs = 1'b1; known = 1;
    case (op)
      6'h00: if (ins[5:0] == 6'h08) begin d.alu = 4'h9; d.bt = 2'd2; end
             else begin d.alu = 4'h2; d.reg_dst = 1; d.reg_write = 1; d.rrt = 1; end
      6'h01: begin
        d.bt = 2'd3;
        if (rt == 5'd1) d.alu = 4'h3; else if (rt == 5'd0) d.alu = 4'h8; else known = 0;
      end
      6'h02: begin d.alu = 4'h9; d.bt = 2'd1; d.rrs = 0; end
      6'h03: begin d.alu = 4'h9; d.bt = 2'd1; d.rrs = 0; d.reg_write = 1; d.jal = 1; end
      6'h04: begin d.alu = 4'h4; d.bt = 2'd3; d.rrt = 1; end
      6'h05: begin d.alu = 4'h5; d.bt = 2'd3; d.rrt = 1; end
      6'h07: begin d.alu = 4'h6; d.bt = 2'd3; end
      6'h06: begin d.alu = 4'h7; d.bt = 2'd3; end
      6'h08: begin d.alu = 4'h1; d.alu_src = 1; d.reg_write = 1; end
      6'h0c: begin d.alu = 4'ha; d.alu_src = 1; d.reg_write = 1; end
      6'h0d: begin d.alu = 4'hb; d.alu_src = 1; d.reg_write = 1; end
      6'h0e: begin d.alu = 4'hc; d.alu_src = 1; d.reg_write = 1; end
      6'h0a: begin d.alu = 4'hd; d.alu_src = 1; d.reg_write = 1; end
      6'h23, 6'h21, 6'h20: begin d.alu_src = 1; d.mem_read = 1; d.mem_to_reg = 1; d.reg_write = 1; end
      6'h2b, 6'h29, 6'h28: begin d.alu_src = 1; d.mem_write = 1; d.rrt = 1; end
      6'h1c: begin d.alu = 4'hf; d.reg_dst = 1; d.reg_write = 1; d.rrt = 1; d.is_mul = 1; end
      default: known = 0;
    endcase
    d.wreg = d.jal ? 5'd31 : (d.reg_dst ? rd : rt);
    if (d.wreg == 5'd0) d.reg_write = 0;
    if (!known) d = '0;
    return d;
  endfunction

  function automatic logic [31:0] rand_instr();
    int rs, rt, rd;
    logic [15:0] imm;
    rs = $urandom_range(0, 3); rt = $urandom_range(0, 3); rd = $urandom_range(0, 3);
    imm = 16'($urandom);
    case ($urandom_range(0, 11))
      0, 11: return enc_r(rs, rt, rd, ($urandom_range(0, 7) == 0) ? 6'h08 : 6'h20);
      1: begin
        logic [5:0] ops [5];
        ops = '{6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0a};
        return enc_i(ops[$urandom_range(0, 4)], rs, rt, imm);
      end
      2: return enc_i(($urandom_range(0, 1) != 0) ? 6'h21 : 6'h20, rs, rt, imm);
      3: return enc_i(($urandom_range(0, 1) != 0) ? 6'h2b : 6'h28, rs, rt, imm);
      4: return {6'h1c, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h02};
      5: return enc_i(6'h01, rs, $urandom_range(0, 1), imm);
      6: return enc_i(($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05, rs, rt, imm);
      7: return enc_i(($urandom_range(0, 1) != 0) ? 6'h06 : 6'h07, rs, rt, imm);
      8: return {6'h02, 26'($urandom)};
      9: return {6'h03, 26'($urandom)};
      default: return enc_i(6'h23, rs, rt, imm);
    endcase
  endfunction

  task automatic drive(input logic [31:0] ins, input logic v, input logic bt);
    Instr = ins; InstrValid = v; BranchTaken = bt;
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin drive(32'h0, 1'b0, 1'b0); tick(); end
  endtask

  task automatic test_reset();
    drive(enc_i(6'h23, 9, 8, 16'h0), 1'b1, 1'b1);
    Rst = 1'b1;
    @(negedge Clk);
    checks++;
    if (outs() !== 22'h0) begin errors++; $display("FAIL reset_outs got %h want 000000", outs()); end
    tick(); tick();
    Rst = 1'b0;
    idle(1);
    @(negedge Clk);
    checks++;
    if (outs() !== 22'h0) begin errors++; $display("FAIL reset_idle got %h want 000000", outs()); end
    tick();
  endtask

  task automatic test_edge_decodes();
    idle(1);
    drive(enc_i(6'h08, 1, 0, 16'd5), 1'b1, 1'b0); tick();
    drive(32'hfc00_1234, 1'b1, 1'b0);
    @(negedge Clk);
    checks++;
    if ({ExValid, ExRegWrite, ExALUOp, ExALUSrc} !== 7'b1_0_0001_1) begin
      errors++; $display("FAIL addi_r0 got v=%b rw=%b op=%b src=%b want 1 0 0001 1", ExValid, ExRegWrite, ExALUOp, ExALUSrc);
    end
    tick();
    drive(enc_i(6'h01, 3, 2, 16'h0), 1'b1, 1'b0);
    @(negedge Clk);
    checks++;
    if (outs() !== 22'h8) begin errors++; $display("FAIL illegal_op got %h want 000008", outs()); end
    tick();
    drive(32'h0, 1'b0, 1'b0);
    @(negedge Clk);
    checks++;
    if (outs() !== 22'h8) begin errors++; $display("FAIL bad_regimm got %h want 000008", outs()); end
    tick();
  endtask

  task automatic test_jal_jr();
    idle(1);
    drive({6'h03, 26'h123456}, 1'b1, 1'b0); tick();
    drive(enc_r(31, 0, 0, 6'h08), 1'b1, 1'b0);
    @(negedge Clk);
    checks++;
    if ({ExWriteReg, ExJal, ExRegWrite, ExBranchType, ExALUOp} !== {5'd31, 1'b1, 1'b1, 2'd1, 4'h9}) begin
      errors++; $display("FAIL jal got wr=%0d jal=%b rw=%b bt=%0d op=%h want 31 1 1 1 9", ExWriteReg, ExJal, ExRegWrite, ExBranchType, ExALUOp);
    end
    tick();
    drive(32'h0, 1'b0, 1'b0);
    @(negedge Clk);
    checks++;
    if ({ExBranchType, ExRegWrite, ExALUOp, ExValid} !== {2'd2, 1'b0, 4'h9, 1'b1}) begin
      errors++; $display("FAIL jr got bt=%0d rw=%b op=%h v=%b want 2 0 9 1", ExBranchType, ExRegWrite, ExALUOp, ExValid);
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [31:0] add_i;
    add_i = enc_r(8, 11, 10, 6'h20);
    idle(1);
    drive(enc_i(6'h23, 9, 8, 16'h0), 1'b1, 1'b0); tick();
    drive(add_i, 1'b1, 1'b0);
    @(negedge Clk);
    checks++;
    if ({StallIF, ExMemRead, ExWriteReg} !== {1'b1, 1'b1, 5'd8}) begin
      errors++; $display("FAIL lu_stall got st=%b mr=%b wr=%0d want 1 1 8", StallIF, ExMemRead, ExWriteReg);
    end
    tick();
    drive(add_i, 1'b1, 1'b0);
    @(negedge Clk);
    checks++;
    if ({ExValid, StallIF} !== 2'b00) begin errors++; $display("FAIL lu_bubble got v=%b st=%b want 0 0", ExValid, StallIF); end
    tick();
    drive(32'h0, 1'b0, 1'b0);
    @(negedge Clk);
    checks++;
    if ({ExValid, ExRegDst, ExALUOp, ExWriteReg, StallIF} !== {1'b1, 1'b1, 4'b0010, 5'd10, 1'b0}) begin
      errors++; $display("FAIL lu_add got v=%b rd=%b op=%b wr=%0d st=%b want 1 1 0010 10 0", ExValid, ExRegDst, ExALUOp, ExWriteReg, StallIF);
    end
    tick();
  endtask

  task automatic test_mul();
    int busy_cycles;
    idle(1);
    drive({6'h1c, 5'd4, 5'd5, 5'd3, 5'd0, 6'h02}, 1'b1, 1'b0); tick();
    busy_cycles = 0;
    for (int c = 1; c <= 3; c++) begin
      drive(enc_i(6'h08, 7, 6, 16'd1), 1'b1, 1'b0);
      @(negedge Clk);
      if (MulBusy && StallIF) busy_cycles++;
      checks++;
      if ({ExALUOp, ExWriteReg, ExValid} !== {4'hf, 5'd3, 1'b1}) begin
        errors++; $display("FAIL mul_hold_c%0d got op=%h wr=%0d v=%b want f 3 1", c, ExALUOp, ExWriteReg, ExValid);
      end
      tick();
    end
    checks++;
    if (busy_cycles != MUL_LAT - 1) begin errors++; $display("FAIL mul_busy_len got %0d want %0d", busy_cycles, MUL_LAT - 1); end
    drive(32'h0, 1'b0, 1'b0);
    @(negedge Clk);
    checks++;
    if ({ExALUOp, ExWriteReg, MulBusy} !== {4'h1, 5'd6, 1'b0}) begin
      errors++; $display("FAIL mul_next got op=%h wr=%0d busy=%b want 1 6 0", ExALUOp, ExWriteReg, MulBusy);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] m2;
    m2 = {6'h1c, 5'd1, 5'd2, 5'd7, 5'd0, 6'h02};
    idle(1);
    drive({6'h1c, 5'd4, 5'd5, 5'd3, 5'd0, 6'h02}, 1'b1, 1'b0); tick();
    for (int c = 1; c <= 6; c++) begin
      drive((c <= 3) ? m2 : enc_i(6'h0d, 1, 2, 16'h7), 1'b1, 1'b0);
      @(negedge Clk);
      checks++;
      if ({ExWriteReg, MulBusy} !== {(c <= 3) ? 5'd3 : 5'd7, (c == 1 || c == 2 || c == 4 || c == 5)}) begin
        errors++; $display("FAIL b2b_c%0d got wr=%0d busy=%b", c, ExWriteReg, MulBusy);
      end
      tick();
    end
    drive(32'h0, 1'b0, 1'b0);
    @(negedge Clk);
    checks++;
    if ({ExALUOp, ExWriteReg} !== {4'hb, 5'd2}) begin errors++; $display("FAIL b2b_after got op=%h wr=%0d want b 2", ExALUOp, ExWriteReg); end
    tick();
  endtask

  task automatic test_branch_flush();
    idle(1);
    drive(enc_i(6'h04, 1, 2, 16'h10), 1'b1, 1'b0); tick();
    drive(enc_i(6'h08, 3, 4, 16'h1), 1'b1, 1'b1);
    @(negedge Clk);
    checks++;
    if ({FlushID, StallIF, ExBranchType, ExALUOp} !== {1'b1, 1'b0, 2'd3, 4'h4}) begin
      errors++; $display("FAIL br_flush got fl=%b st=%b bt=%0d op=%h want 1 0 3 4", FlushID, StallIF, ExBranchType, ExALUOp);
    end
    tick();
    drive(32'h0, 1'b0, 1'b0);
    @(negedge Clk);
    checks++;
    if ({ExValid, FlushID} !== 2'b00) begin errors++; $display("FAIL br_bubble got v=%b fl=%b want 0 0", ExValid, FlushID); end
    tick();
    drive(enc_i(6'h23, 9, 8, 16'h0), 1'b1, 1'b0); tick();
    drive(enc_r(8, 11, 10, 6'h20), 1'b1, 1'b1);
    @(negedge Clk);
    checks++;
    if ({FlushID, StallIF} !== 2'b10) begin errors++; $display("FAIL br_vs_lu got fl=%b st=%b want 1 0", FlushID, StallIF); end
    tick();
    drive(32'h0, 1'b0, 1'b0);
    @(negedge Clk);
    checks++;
    if (ExValid !== 1'b0) begin errors++; $display("FAIL br_lu_bubble got v=%b want 0", ExValid); end
    tick();
  endtask

  task automatic test_reset_mid_mul();
    idle(1);
    drive({6'h1c, 5'd4, 5'd5, 5'd3, 5'd0, 6'h02}, 1'b1, 1'b0); tick();
    @(negedge Clk);
    checks++;
    if (MulBusy !== 1'b1) begin errors++; $display("FAIL rstmul_busy got %b want 1", MulBusy); end
    #2 Rst = 1'b1;
    #1;
    checks++;
    if (outs() !== 22'h0) begin errors++; $display("FAIL rstmul_outs got %h want 000000", outs()); end
    tick();
    Rst = 1'b0;
    drive(enc_i(6'h0d, 3, 2, 16'h7), 1'b1, 1'b0);
    @(negedge Clk);
    checks++;
    if ({ExValid, MulBusy, StallIF} !== 3'b000) begin errors++; $display("FAIL rstmul_rel got v=%b busy=%b st=%b want 0 0 0", ExValid, MulBusy, StallIF); end
    tick();
    drive(32'h0, 1'b0, 1'b0);
    @(negedge Clk);
    checks++;
    if ({ExValid, ExALUOp, ExWriteReg, MulBusy} !== {1'b1, 4'hb, 5'd2, 1'b0}) begin
      errors++; $display("FAIL rstmul_ori got v=%b op=%h wr=%0d busy=%b want 1 b 2 0", ExValid, ExALUOp, ExWriteReg, MulBusy);
    end
    tick();
  endtask

  // Random stream: the bench acts as the fetch stage, holding IF/ID when the
  // model says stall and inserting a bubble after a flush.
  task automatic test_random(input int n);
    exp_t        m_ex, dec;
    logic        m_valid, hold, flushed, e_stall, e_flush, e_busy, lu;
    int          mul_left;
    logic [31:0] cur;
    logic        cur_v, bt;
    logic [21:0] want;
    Rst = 1'b1; tick(); Rst = 1'b0;
    m_ex = '0; m_valid = 0; mul_left = 0; hold = 0; flushed = 0; cur = 32'h0; cur_v = 0;
    for (int i = 0; i < n; i++) begin
      if (!hold) begin
        cur   = rand_instr();
        cur_v = !flushed && ($urandom_range(0, 7) != 0);
      end
      bt = ($urandom_range(0, 9) == 0);
      drive(cur, cur_v, bt);
      dec = model_decode(cur);
      if (mul_left > 0) begin
        e_stall = 1; e_flush = 0; e_busy = 1; lu = 0;
      end else begin
        lu = m_valid && m_ex.mem_read && (m_ex.wreg != 0) && cur_v &&
             ((dec.rrs && cur[25:21] == m_ex.wreg) || (dec.rrt && cur[20:16] == m_ex.wreg));
        e_flush = bt; e_stall = lu && !bt; e_busy = 0;
      end
      want = {m_ex.reg_dst, m_ex.mem_read, m_ex.mem_to_reg, m_ex.mem_write, m_ex.alu_src,
              m_ex.reg_write, m_ex.jal, m_ex.alu, m_ex.bt, m_ex.wreg, m_valid, e_stall, e_flush, e_busy};
      @(negedge Clk);
      checks++;
      if (outs() !== want) begin
        errors++; $display("FAIL rand_%0d instr=%h v=%b bt=%b got %h want %h", i, cur, cur_v, bt, outs(), want);
      end
      tick();
      if (mul_left > 0) mul_left--;
      else if (bt || lu || !cur_v) begin m_ex = '0; m_valid = 0; end
      else begin
        m_ex = dec; m_valid = 1;
        if (dec.is_mul) mul_left = MUL_LAT - 1;
      end
      hold = e_stall; flushed = e_flush;
    end
    idle(MUL_LAT + 1);
  endtask

  initial begin
    Rst = 1'b1;
    drive(32'h0, 1'b0, 1'b0);
    test_reset();
    test_edge_decodes();
    test_jal_jr();
    test_load_use();
    test_mul();
    test_back_to_back();
    test_branch_flush();
    test_reset_mid_mul();
    test_random(2000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_controller.md
# pipe_controller

Pipelined successor to the single-cycle control decoder. It sits between the IF/ID register and the EX stage of the 5-stage MIPS datapath. It decodes the ID-stage instruction and registers the control bundle plus resolved destination register into the ID/EX control slice. It also generates load-use stalls, multi-cycle `mul` stalls and branch/jump flushes.

## Interface
- `MUL_LATENCY`, 3: cycles a `mul` occupies EX; legal range ≥1.
- `LOAD_USE_EN`, 1: 1 = detect load-use hazards; 0 = forwarding unit handles them, never stall.
- `Clk  in  1`: single clock, rising edge.
- `Rst  in  1`: reset, asynchronous and active-high.
- `Instr  in  32`: instruction from IF/ID.
- `InstrValid  in  1`: IF/ID holds a real instruction.
- `BranchTaken  in  1`: EX resolved a taken branch/jump/jr this cycle.
- `ExRegDst, ExMemRead, ExMemToReg, ExMemWrite, ExALUSrc, ExRegWrite, ExJal  out  1 each`: registered control for EX.
- `ExALUOp  out  4`: registered ALU operation.
- `ExBranchType  out  2`: 0 none, 1 j/jal, 2 jr, 3 conditional.
- `ExWriteReg  out  5`: resolved destination (rd, rt or 31).
- `ExValid  out  1`: EX slot holds a real instruction.
- `StallIF  out  1`: hold PC and IF/ID this cycle.
- `FlushID  out  1`: load bubble into IF/ID at next edge.
- `MulBusy  out  1`: multi-cycle `mul` in progress.

## Operation
- Decode map (opcode → ALUOp, ALUSrc, RegDst, RegWrite, mem): R-type → 0010 RR RegDst=1 wr. jr (op 0, funct 001000) → 1001, BranchType 2, RegWrite 0. addi 001000 → 0001. andi 001100 → 1010. ori 001101 → 1011. xori 001110 → 1100. slti 001010 → 1101. All immediates: ALUSrc=1, wr, rt dest. lw/lh/lb 100011/100001/100000 → 0000 MemRead MemToReg wr. sw/sh/sb 101011/101001/101000 → 0000 MemWrite. mul 011100 → 1111 RegDst=1 wr. regimm 000001 with rt=00001 bgez → 0011, rt=00000 bltz → 1000. beq 0100, bne 0101, bgtz 0110, blez 0111. j 000010 → 1001 type 1. jal 000011 → 1001 type 1, wr, Jal, dest 31.
- Unknown opcode or unknown regimm rt: all-zero bundle, ExValid still 1 (a NOP).
- Writes to register 0 decode normally, with ExRegWrite forced 0.
- Reads-rs: all except j, jal. Reads-rt: R-type, jr excluded, mul, stores, beq, bne.
- Load-use (LOAD_USE_EN=1): ExValid & ExMemRead & ExWriteReg≠0 & InstrValid, and ExWriteReg matches a read rs/rt. Response: StallIF=1, bubble into EX.
- FSM states RUN and MUL_WAIT. In RUN, a mul advancing into EX with MUL_LATENCY>1 loads counter with MUL_LATENCY−1 and enters MUL_WAIT.
- In MUL_WAIT the EX registers hold and MulBusy=1. StallIF=1 and the counter decrements. At counter=1 the FSM returns to RUN on the next edge. Counter width: $clog2(MUL_LATENCY+1).
- EX-load priority: Rst > MUL_WAIT hold > BranchTaken (bubble, FlushID=1) > load-use bubble > normal decode.
- BranchTaken is ignored in MUL_WAIT. A bubble has all controls 0 and ExValid 0.
- InstrValid=0 loads a bubble.

## Timing
- Decode-to-EX latency: 1 cycle.
- StallIF, FlushID and MulBusy are combinational from state, EX registers, Instr and BranchTaken.
- Reset value of every output is 0. FSM resets to RUN, counter to 0. Stall/flush outputs read 0 during reset.
- Rst mid-MUL_WAIT: immediate return to RUN, counter cleared, EX bubble.
- Load-use plus BranchTaken in the same cycle: flush wins, StallIF=0.
- Back-to-back muls: second mul enters EX on the cycle after MUL_WAIT exits, then waits its own MUL_LATENCY−1 cycles.
- MUL_LATENCY=1: MUL_WAIT is never entered.

## Structure
- Shared package `mips_ctrl_pkg`: opcode/funct/regimm constants, ALUOp codes, BranchType enum and the control-bundle struct (reused by the datapath).
- One sub-module `ctrl_decode`: purely combinational Instr → bundle, plus reads-rs/reads-rt and dest.
- The top holds the ID/EX control register, hazard logic, FSM and counter.

## Test plan
- Reset during a mul stall. Rst pulsed mid-stall → all outputs 0, FSM in RUN. First instruction after release decodes one cycle later.
- Load-use stall. `lw $8,0($9)` then `add $10,$8,$11` → StallIF=1 for exactly 1 cycle. EX shows bubble (ExValid=0), then the add with ExRegDst=1, ExALUOp=0010, ExWriteReg=10.
- Multi-cycle mul. `mul $3,$4,$5` with MUL_LATENCY=3 → MulBusy=1 and StallIF=1 for 2 cycles. ExALUOp=1111 held, next instruction enters EX on cycle 4.
- Branch flush. BranchTaken=1 with beq in EX → FlushID=1 that cycle, next EX is a bubble. With a simultaneous load-use condition, StallIF=0.
- jal and jr decode. jal → ExWriteReg=31, ExJal=1, ExRegWrite=1, ExBranchType=1. jr $31 → ExBranchType=2, ExRegWrite=0.
- Edge decodes. `addi $0,$1,5` → ExRegWrite=0. Illegal opcode 111111 → all-zero bundle with ExValid=1.
